pixel_unpacker: RTL and testbench

- Receive side of the packed 24-bit RGB AXI-Stream video format produced by the pixel packer. Consumes 32-bit words (4 pixels per 3 words) and emits one RGB pixel per handshake with x/y coordinates.
- Checks frame framing: tuser marks start of frame, tlast marks end of line. Resynchronises after framing errors.
- Sits between a VDMA/stream source and downstream pixel consumers such as the display checker and frame compare logic.

---
 rtl/pixel_unpacker.sv | 297 +++++++++++++++++++++++++++++
 tb/tb_pixel_unpacker.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_unpacker.sv
// pixel_unpacker
// Receive side of the packed 24-bit RGB AXI-Stream video format: three 32-bit
// words carry four pixels as B,G,R byte triplets. Emits one pixel per
// handshake with x/y coordinates, checks tuser/tlast framing and
// resynchronises after framing errors.
// Optional feature: define PIXEL_UNPACKER_ERR_COUNT_EN to add a saturating
// 16-bit err_count output that counts every err_* pulse.
module pixel_unpacker #(
  parameter int X_SIZE = 640,
  parameter int Y_SIZE = 480,
  parameter int XY_W   = 11
) (
  input  logic            aclk,
  input  logic            reset,
  input  logic [31:0]     in_stream_tdata,
  input  logic [3:0]      in_stream_tkeep,
  input  logic            in_stream_tlast,
  input  logic            in_stream_tuser,
  input  logic            in_stream_tvalid,
  output logic            in_stream_tready,
  output logic [7:0]      pix_r,
  output logic [7:0]      pix_g,
  output logic [7:0]      pix_b,
  output logic [XY_W-1:0] pix_x,
  output logic [XY_W-1:0] pix_y,
  output logic            pix_sof,
  output logic            pix_eol,
  output logic            pix_valid,
  input  logic            pix_ready,
  output logic            err_short_line,
  output logic            err_long_line,
  output logic            err_early_sof
`ifdef PIXEL_UNPACKER_ERR_COUNT_EN
  ,
  output logic [15:0]     err_count
`endif
);

  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic [7:0]      r;
    logic [7:0]      g;
    logic [7:0]      b;
    logic [XY_W-1:0] x;
    logic [XY_W-1:0] y;
    logic            sof;
    logic            eol;
  } pix_t;

  localparam int              PIX_W    = $bits(pix_t);
  localparam logic [PIX_W-1:0] PIX_ZERO = {PIX_W{1'b0}};
  localparam logic [XY_W-1:0] XY_ZERO  = {XY_W{1'b0}};
  localparam logic [XY_W-1:0] XY_ONE   = XY_W'(1);
  localparam logic [XY_W-1:0] XY_TWO   = XY_W'(2);
  localparam logic [XY_W-1:0] X_LAST   = XY_W'(X_SIZE - 1);
  localparam logic [XY_W-1:0] X_PRE    = XY_W'(X_SIZE - 2);
  localparam logic [XY_W-1:0] Y_LAST   = XY_W'(Y_SIZE - 1);

  // Builds an output pixel and derives its frame/line markers from the coordinate.
  function automatic pix_t make_pix(input logic [7:0] r, input logic [7:0] g,
                                    input logic [7:0] b, input logic [XY_W-1:0] x,
                                    input logic [XY_W-1:0] y);
    pix_t p;
    p.r   = r;
    p.g   = g;
    p.b   = b;
    p.x   = x;
    p.y   = y;
    p.sof = (x == XY_ZERO) && (y == XY_ZERO);
    p.eol = (x == X_LAST);
    return p;
  endfunction

  state_t          state_r, state_s;
  logic [1:0]      phase_r, phase_s;
  logic [15:0]     carry_r, carry_s;
  logic [XY_W-1:0] x_r, x_s, y_r, y_s;
  pix_t            out_r, pend_r;
  logic            out_valid_r, pend_valid_r;
  logic            err_short_r, err_long_r, err_sof_r;

  logic            out_free_s, tready_s, accept_s, at_origin_s;
  logic            early_sof_s, restart_s, process_s;
  logic [1:0]      eff_phase_s;
  logic [15:0]     eff_carry_s;
  logic [XY_W-1:0] eff_x_s, eff_y_s, y_inc_s;
  logic [7:0]      byte0_s, byte1_s, byte2_s, byte3_s;
  pix_t            pix_a_s, pix_b_s;
  logic            two_s, last_word_s, short_s, long_s;
  logic            tkeep_unused_s;

  // tkeep carries no information here: every byte of a word is a pixel byte.
  assign tkeep_unused_s = ^in_stream_tkeep;

  // Handshake, word decode, pixel assembly, framing checks and next-state selection.
  always_comb begin
    state_s     = state_r;
    phase_s     = phase_r;
    carry_s     = carry_r;
    x_s         = x_r;
    y_s         = y_r;
    pix_a_s     = PIX_ZERO;
    pix_b_s     = PIX_ZERO;
    two_s       = 1'b0;
    carry_s     = carry_r;

    byte0_s = in_stream_tdata[7:0];
    byte1_s = in_stream_tdata[15:8];
    byte2_s = in_stream_tdata[23:16];
    byte3_s = in_stream_tdata[31:24];

    out_free_s = !out_valid_r || pix_ready;
    // SYNC only stalls if a pixel of the previous frame is still held in the output.
    case (state_r)
      ST_SYNC:  tready_s = out_free_s && !pend_valid_r;
      ST_RUN:   tready_s = out_free_s && !pend_valid_r;
      ST_DRAIN: tready_s = 1'b1;
      default:  tready_s = 1'b0;
    endcase
    accept_s = in_stream_tvalid && tready_s;

    at_origin_s = (x_r == XY_ZERO) && (y_r == XY_ZERO) && (phase_r == 2'd0);
    early_sof_s = accept_s && (state_r == ST_RUN) && in_stream_tuser && !at_origin_s;
    restart_s   = early_sof_s || (accept_s && (state_r == ST_SYNC) && in_stream_tuser);
    process_s   = (accept_s && (state_r == ST_RUN)) || restart_s;

    // A start-of-frame word is always unpacked as phase 0 of pixel (0,0).
    if (restart_s) begin
      eff_phase_s = 2'd0;
      eff_carry_s = 16'h0000;
      eff_x_s     = XY_ZERO;
      eff_y_s     = XY_ZERO;
    end else begin
      eff_phase_s = phase_r;
      eff_carry_s = carry_r;
      eff_x_s     = x_r;
      eff_y_s     = y_r;
    end
    y_inc_s = (eff_y_s == Y_LAST) ? XY_ZERO : (eff_y_s + XY_ONE);

    case (eff_phase_s)
      2'd0: begin
        pix_a_s = make_pix(byte2_s, byte1_s, byte0_s, eff_x_s, eff_y_s);
        carry_s = {8'h00, byte3_s};
      end
      2'd1: begin
        pix_a_s = make_pix(byte1_s, byte0_s, eff_carry_s[7:0], eff_x_s, eff_y_s);
        carry_s = {byte3_s, byte2_s};
      end
      2'd2: begin
        pix_a_s = make_pix(byte0_s, eff_carry_s[15:8], eff_carry_s[7:0], eff_x_s, eff_y_s);
        pix_b_s = make_pix(byte3_s, byte2_s, byte1_s, eff_x_s + XY_ONE, eff_y_s);
        two_s   = 1'b1;
        carry_s = 16'h0000;
      end
      default: begin
        carry_s = 16'h0000;
      end
    endcase
    if (!process_s) begin
      carry_s = carry_r;
    end else begin
      carry_s = carry_s;
    end

    // The last word of a line is the phase-2 word that completes pixel X_SIZE-1.
    last_word_s = (eff_phase_s == 2'd2) && (eff_x_s == X_PRE);
    short_s     = process_s && in_stream_tlast && !last_word_s;
    long_s      = process_s && !in_stream_tlast && last_word_s;

    if (process_s) begin
      if (long_s) begin
        state_s = ST_DRAIN;
        phase_s = 2'd0;
        carry_s = 16'h0000;
        x_s     = XY_ZERO;
        y_s     = eff_y_s;
      end else if (in_stream_tlast || last_word_s) begin
        state_s = ST_RUN;
        phase_s = 2'd0;
        carry_s = 16'h0000;
        x_s     = XY_ZERO;
        y_s     = y_inc_s;
      end else begin
        state_s = ST_RUN;
        phase_s = two_s ? 2'd0 : (eff_phase_s + 2'd1);
        x_s     = eff_x_s + (two_s ? XY_TWO : XY_ONE);
        y_s     = eff_y_s;
      end
    end else if (accept_s && (state_r == ST_DRAIN) && in_stream_tlast) begin
      phase_s = 2'd0;
      carry_s = 16'h0000;
      x_s     = XY_ZERO;
      if (y_r == Y_LAST) begin
        y_s     = XY_ZERO;
        state_s = ST_SYNC;
      end else begin
        y_s     = y_r + XY_ONE;
        state_s = ST_RUN;
      end
    end else begin
      state_s = state_r;
    end
  end

  // Framing state, unpack phase, byte carry and next-pixel coordinate.
  always_ff @(posedge aclk) begin
    if (reset) begin
      state_r <= ST_SYNC;
      phase_r <= 2'd0;
      carry_r <= 16'h0000;
      x_r     <= XY_ZERO;
      y_r     <= XY_ZERO;
    end else begin
      state_r <= state_s;
      phase_r <= phase_s;
      carry_r <= carry_s;
      x_r     <= x_s;
      y_r     <= y_s;
    end
  end

  // Output pixel register with a one-deep pending slot for the second phase-2 pixel.
  always_ff @(posedge aclk) begin
    if (reset) begin
      out_r        <= PIX_ZERO;
      pend_r       <= PIX_ZERO;
      out_valid_r  <= 1'b0;
      pend_valid_r <= 1'b0;
      err_short_r  <= 1'b0;
      err_long_r   <= 1'b0;
      err_sof_r    <= 1'b0;
    end else begin
      if (process_s) begin
        out_r        <= pix_a_s;
        out_valid_r  <= 1'b1;
        pend_r       <= pix_b_s;
        pend_valid_r <= two_s;
      end else if (out_valid_r && pix_ready) begin
        if (pend_valid_r) begin
          out_r        <= pend_r;
          pend_valid_r <= 1'b0;
        end else begin
          out_valid_r <= 1'b0;
        end
      end
      err_short_r <= short_s;
      err_long_r  <= long_s;
      err_sof_r   <= early_sof_s;
    end
  end

  assign in_stream_tready = tready_s && !reset;
  assign pix_r            = out_r.r;
  assign pix_g            = out_r.g;
  assign pix_b            = out_r.b;
  assign pix_x            = out_r.x;
  assign pix_y            = out_r.y;
  assign pix_sof          = out_r.sof;
  assign pix_eol          = out_r.eol;
  assign pix_valid        = out_valid_r;
  assign err_short_line   = err_short_r;
  assign err_long_line    = err_long_r;
  assign err_early_sof    = err_sof_r;

`ifdef PIXEL_UNPACKER_ERR_COUNT_EN
  logic [15:0] err_cnt_r;
  logic [16:0] err_sum_s;

  // Adds this cycle's error events to the running count.
  always_comb begin
    err_sum_s = {1'b0, err_cnt_r} + {16'h0000, short_s} + {16'h0000, long_s}
              + {16'h0000, early_sof_s};
  end

  // Error counter saturating at all-ones; only reset clears it.
  always_ff @(posedge aclk) begin
    if (reset) begin
      err_cnt_r <= 16'h0000;
    end else if (err_sum_s[16]) begin
      err_cnt_r <= 16'hFFFF;
    end else begin
      err_cnt_r <= err_sum_s[15:0];
    end
  end

  assign err_count = err_cnt_r;
`else
  // No error counter in this build.
`endif

endmodule

// File: tb/tb_pixel_unpacker.sv
// Directed bench for pixel_unpacker with an 8x2 frame (6 words per line).
module tb_pixel_unpacker;

  localparam int XS = 8;
  localparam int YS = 2;
  localparam int XW = 11;

  typedef struct packed {
    logic [7:0]    r;
    logic [7:0]    g;
    logic [7:0]    b;
    logic [XW-1:0] x;
    logic [XW-1:0] y;
    logic          sof;
    logic          eol;
  } pix_t;

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic        user;
  } word_t;

  typedef struct {
    int   idx;
    pix_t px;
  } key_t;

  logic          aclk = 1'b0;
  logic          reset = 1'b1;
  logic [31:0]   in_stream_tdata = 32'h0;
  logic [3:0]    in_stream_tkeep = 4'hF;
  logic          in_stream_tlast = 1'b0;
  logic          in_stream_tuser = 1'b0;
  logic          in_stream_tvalid = 1'b0;
  logic          in_stream_tready;
  logic [7:0]    pix_r, pix_g, pix_b;
  logic [XW-1:0] pix_x, pix_y;
  logic          pix_sof, pix_eol, pix_valid;
  logic          pix_ready = 1'b1;
  logic          err_short_line, err_long_line, err_early_sof;
`ifdef PIXEL_UNPACKER_ERR_COUNT_EN
  logic [15:0]   err_count;
`endif

  pixel_unpacker #(.X_SIZE(XS), .Y_SIZE(YS), .XY_W(XW)) dut (
    .aclk(aclk), .reset(reset),
    .in_stream_tdata(in_stream_tdata), .in_stream_tkeep(in_stream_tkeep),
    .in_stream_tlast(in_stream_tlast), .in_stream_tuser(in_stream_tuser),
    .in_stream_tvalid(in_stream_tvalid), .in_stream_tready(in_stream_tready),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b), .pix_x(pix_x), .pix_y(pix_y),
    .pix_sof(pix_sof), .pix_eol(pix_eol), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .err_short_line(err_short_line), .err_long_line(err_long_line),
    .err_early_sof(err_early_sof)
`ifdef PIXEL_UNPACKER_ERR_COUNT_EN
    , .err_count(err_count)
`endif
  );

  always #5 aclk = ~aclk;

  int     errors = 0;
  int     checks = 0;
  pix_t   got_q[$];
  pix_t   exp_q[$];
  bit     collect = 1'b1;
  int     n_short = 0, n_long = 0, n_sof = 0;
  logic [7:0] fbyte [48];
  word_t  fw [12];
  key_t   keys [5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Expected pixel n of the frame, derived directly from the byte-order rule.
  function automatic pix_t exp_pix(input int n);
    pix_t p;
    p.b   = fbyte[3*n];
    p.g   = fbyte[3*n+1];
    p.r   = fbyte[3*n+2];
    p.x   = XW'(n % XS);
    p.y   = XW'(n / XS);
    p.sof = (n == 0);
    p.eol = ((n % XS) == XS - 1);
    return p;
  endfunction

  // Output monitor: records handshaken pixels, error pulses and checks stall stability.
  pix_t cur_px, prev_px;
  bit   prev_stall = 1'b0;
  always @(negedge aclk) begin
    cur_px = {pix_r, pix_g, pix_b, pix_x, pix_y, pix_sof, pix_eol};
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) check("stall_hold", {15'h0, pix_valid, cur_px}, {15'h0, 1'b1, prev_px});
      if (pix_valid && pix_ready && collect) got_q.push_back(cur_px);
      if (err_short_line) n_short++;
      if (err_long_line) n_long++;
      if (err_early_sof) n_sof++;
      prev_stall = pix_valid && !pix_ready;
      prev_px    = cur_px;
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    in_stream_tvalid = 1'b0;
    in_stream_tuser  = 1'b0;
    in_stream_tlast  = 1'b0;
    pix_ready        = 1'b1;
    repeat (3) @(posedge aclk);
    #1 reset = 1'b0;
    got_q.delete();
    exp_q.delete();
    n_short = 0;
    n_long  = 0;
    n_sof   = 0;
  endtask

  // Offers one word; must be called just after a rising edge.
  task automatic send_word(input logic [31:0] d, input logic l, input logic u);
    bit done;
    done = 1'b0;
    in_stream_tdata  = d;
    in_stream_tlast  = l;
    in_stream_tuser  = u;
    in_stream_tvalid = 1'b1;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge aclk);
      if (in_stream_tready) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_word_timeout: tready stayed %b, expected 1", in_stream_tready);
    end
    @(posedge aclk);
    #1 in_stream_tvalid = 1'b0;
  endtask

  task automatic send_fw(input int w);
    send_word(fw[w].data, fw[w].last, fw[w].user);
  endtask

  task automatic add_exp(input int lo, input int hi);
    for (int n = lo; n <= hi; n++) exp_q.push_back(exp_pix(n));
  endtask

  // Waits for the expected pixel count, then compares the stream element by element.
  task automatic check_stream(input string name);
    int lim;
    for (int c = 0; c < 3000 && got_q.size() < exp_q.size(); c++) @(posedge aclk);
    repeat (6) @(posedge aclk);
    #1;
    check({name, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    lim = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < lim; i++) check($sformatf("%s_pix%0d", name, i), 64'(got_q[i]), 64'(exp_q[i]));
    exp_q.delete();
  endtask

  task automatic check_errs(input string name, input int s, input int l, input int f);
    check({name, "_err_short"}, 64'(n_short), 64'(s));
    check({name, "_err_long"},  64'(n_long),  64'(l));
    check({name, "_err_sof"},   64'(n_sof),   64'(f));
  endtask

  initial begin
    for (int k = 0; k < 48; k++) fbyte[k] = 8'((k + 1) * 17);
    for (int w = 0; w < 12; w++) begin
      fw[w].data = {fbyte[4*w+3], fbyte[4*w+2], fbyte[4*w+1], fbyte[4*w]};
      fw[w].last = ((w % 6) == 5);
      fw[w].user = (w == 0);
    end
    keys[0].idx = 0;  keys[0].px = {8'h33, 8'h22, 8'h11, 11'd0, 11'd0, 1'b1, 1'b0};
    keys[1].idx = 1;  keys[1].px = {8'h66, 8'h55, 8'h44, 11'd1, 11'd0, 1'b0, 1'b0};
    keys[2].idx = 7;  keys[2].px = {8'h98, 8'h87, 8'h76, 11'd7, 11'd0, 1'b0, 1'b1};
    keys[3].idx = 8;  keys[3].px = {8'hCB, 8'hBA, 8'hA9, 11'd0, 11'd1, 1'b0, 1'b0};
    keys[4].idx = 15; keys[4].px = {8'h30, 8'h1F, 8'h0E, 11'd7, 11'd1, 1'b0, 1'b1};

    // Reset values, then SYNC accepts words.
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    check("rst_tready", 64'(in_stream_tready), 64'd0);
    check("rst_valid", 64'(pix_valid), 64'd0);
    check("rst_pix", 64'({pix_r, pix_g, pix_b, pix_x, pix_y, pix_sof, pix_eol}), 64'd0);
    check("rst_err", 64'({err_short_line, err_long_line, err_early_sof}), 64'd0);
    @(posedge aclk);
    #1 reset = 1'b0;
    @(negedge aclk);
    check("sync_tready", 64'(in_stream_tready), 64'd1);
    @(posedge aclk);
    #1;

    // Pre-SOF garbage, then two clean frames; the second tuser lands at the origin.
    do_reset();
    for (int i = 0; i < 5; i++) send_word(32'hDEAD_0000 + 32'(i), (i == 2), 1'b0);
    for (int w = 0; w < 12; w++) send_fw(w);
    for (int w = 0; w < 12; w++) send_fw(w);
    add_exp(0, 15);
    add_exp(0, 15);
    check_stream("clean");
    for (int i = 0; i < 5; i++) begin
      if (keys[i].idx < got_q.size())
        check($sformatf("key_pix%0d", keys[i].idx), 64'(got_q[keys[i].idx]), 64'(keys[i].px));
      else
        check($sformatf("key_pix%0d_missing", keys[i].idx), 64'(got_q.size()), 64'(keys[i].idx + 1));
    end
    check_errs("clean", 0, 0, 0);

    // Backpressure toggling every cycle across the whole frame.
    do_reset();
    fork
      begin
        for (int w = 0; w < 12; w++) send_fw(w);
      end
      begin
        for (int c = 0; c < 60; c++) begin
          @(posedge aclk);
          #1 pix_ready = ~pix_ready;
        end
        pix_ready = 1'b1;
      end
    join
    add_exp(0, 15);
    check_stream("bp");
    check_errs("bp", 0, 0, 0);

    // Pending pixel holds off tready; reset drops a pending pixel.
    do_reset();
    send_fw(0);
    @(negedge aclk);
    check("latency_valid", 64'({pix_valid, pix_sof}), 64'b11);
    @(posedge aclk);
    #1;
    send_fw(1);
    send_fw(2);
    pix_ready = 1'b0;
    in_stream_tdata = fw[3].data; in_stream_tlast = 1'b0; in_stream_tuser = 1'b0;
    in_stream_tvalid = 1'b1;
    @(negedge aclk);
    check("stall_tready", 64'(in_stream_tready), 64'd0);
    @(posedge aclk);
    #1 pix_ready = 1'b1;
    @(negedge aclk);
    check("pend_tready", 64'(in_stream_tready), 64'd0);
    check("pend_cur_x", 64'(pix_x), 64'd2);
    @(posedge aclk);
    #1;
    @(negedge aclk);
    check("pend_done_tready", 64'(in_stream_tready), 64'd1);
    check("pend_issued_x", 64'(pix_x), 64'd3);
    @(posedge aclk);
    #1 in_stream_tvalid = 1'b0;
    send_fw(4);
    send_fw(5);
    pix_ready = 1'b0;
    reset = 1'b1;
    @(posedge aclk);
    #1 reset = 1'b0;
    pix_ready = 1'b1;
    repeat (10) @(posedge aclk);
    @(negedge aclk);
    check("midrst_valid", 64'(pix_valid), 64'd0);
    check("midrst_tready", 64'(in_stream_tready), 64'd1);
    @(posedge aclk);
    #1;
    add_exp(0, 5);
    check_stream("midrst");

    // Short line: tlast on word 3 of line 0.
    do_reset();
    for (int w = 0; w < 3; w++) send_fw(w);
    send_word(fw[3].data, 1'b1, 1'b0);
    for (int w = 6; w < 12; w++) send_fw(w);
    add_exp(0, 4);
    add_exp(8, 15);
    check_stream("short");
    check_errs("short", 1, 0, 0);

    // Long line: missing tlast on word 5, two extra words, then line 1.
    do_reset();
    for (int w = 0; w < 5; w++) send_fw(w);
    send_word(fw[5].data, 1'b0, 1'b0);
    send_word(32'hBAD0_0001, 1'b0, 1'b0);
    send_word(32'hBAD0_0002, 1'b1, 1'b0);
    for (int w = 6; w < 12; w++) send_fw(w);
    add_exp(0, 15);
    check_stream("long");
    check_errs("long", 0, 1, 0);

    // Long line on the last line: drain returns to SYNC, which drops garbage.
    do_reset();
    for (int w = 0; w < 11; w++) send_fw(w);
    send_word(fw[11].data, 1'b0, 1'b0);
    send_word(32'hBAD0_0003, 1'b1, 1'b0);
    send_word(32'hBAD0_0004, 1'b0, 1'b0);
    for (int w = 0; w < 12; w++) send_fw(w);
    add_exp(0, 15);
    add_exp(0, 15);
    check_stream("long_last");
    check_errs("long_last", 0, 1, 0);

    // Early SOF at (4,1).
    do_reset();
    for (int w = 0; w < 9; w++) send_fw(w);
    for (int w = 0; w < 12; w++) send_fw(w);
    add_exp(0, 11);
    add_exp(0, 15);
    check_stream("esof");
    check_errs("esof", 0, 0, 1);
`ifdef PIXEL_UNPACKER_ERR_COUNT_EN
    check("esof_err_count", 64'(err_count), 64'd1);
`endif

    // tuser and tlast together at (2,0): restart, then short line on the new line.
    do_reset();
    send_fw(0);
    send_fw(1);
    send_word(fw[0].data, 1'b1, 1'b1);
    for (int w = 6; w < 12; w++) send_fw(w);
    add_exp(0, 1);
    add_exp(0, 0);
    add_exp(8, 15);
    check_stream("both");
    check_errs("both", 1, 0, 1);
`ifdef PIXEL_UNPACKER_ERR_COUNT_EN
    check("both_err_count", 64'(err_count), 64'd2);

    // 70000 back-to-back early-SOF errors saturate the counter.
    do_reset();
    collect = 1'b0;
    send_fw(0);
    in_stream_tdata = fw[0].data; in_stream_tuser = 1'b1; in_stream_tlast = 1'b0;
    in_stream_tvalid = 1'b1;
    repeat (70000) @(posedge aclk);
    #1 in_stream_tvalid = 1'b0;
    in_stream_tuser = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    check("err_count_sat", 64'(err_count), 64'h0000_0000_0000_FFFF);
    collect = 1'b1;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
